ex_branch_resolve: RTL

EX-stage branch/jump resolution unit: the consumer of the speculative fetch redirect that the ID stage makes with its early target generator. It checks each branch/jump in EX against what ID predicted. On a mismatch it issues a one-cycle registered redirect plus a flush of the younger pipeline slots. It also owns the 2-bit branch history table (BHT) that ID reads for its taken/not-taken prediction, and keeps branch and mispredict counters.

---
 rtl/ex_branch_resolve_pkg.sv | 48 ++++
 rtl/ex_branch_resolve_bht_2bit.sv | 32 +++
 rtl/ex_branch_resolve.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ex_branch_resolve_pkg.sv
// Shared constants, types and helpers for EX-stage branch resolution.
// Holds opcode/funct3 encodings, BHT init value, flush-mask bit positions and immediate decoders.
package ex_branch_resolve_pkg;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] BHT_INIT = 2'b01;

  localparam int FLUSH_EX = 2;
  localparam int FLUSH_ID = 1;
  localparam int FLUSH_IF = 0;
  localparam logic [2:0] FLUSH_ALL = (3'b001 << FLUSH_EX) | (3'b001 << FLUSH_ID) | (3'b001 << FLUSH_IF);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } br_state_e;

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{21{inst[31]}}, inst[30:20]};
  endfunction

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) nxt = ctr + 2'b01;
    else if (!taken && ctr != 2'b00) nxt = ctr - 2'b01;
    return nxt;
  endfunction

endpackage

// File: rtl/ex_branch_resolve_bht_2bit.sv
// Table of 2-bit saturating taken/not-taken counters.
// Combinational read; a same-cycle update is only visible after the clock edge.
module bht_2bit
  import ex_branch_resolve_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  localparam int IDX_W = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] ctr_q [BHT_ENTRIES];

  assign rd_ctr = ctr_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        ctr_q[i] <= BHT_INIT;
      end
    end else if (upd_en) begin
      ctr_q[upd_idx] <= sat_update(ctr_q[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/ex_branch_resolve.sv
// EX-stage branch/jump resolution: checks ID's speculative redirect, issues a registered
// redirect + flush on mispredict, owns the BHT and keeps branch/mispredict statistics.
module ex_branch_resolve
  import ex_branch_resolve_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          id_pc,
  output logic                 id_pred_taken,
  input  logic                 ex_valid,
  input  logic [31:0]          ex_inst,
  input  logic [31:0]          ex_pc,
  input  logic [31:0]          ex_rs1,
  input  logic [31:0]          ex_rs2,
  input  logic                 ex_pred_taken,
  input  logic [31:0]          ex_pred_target,
  output logic                 redirect,
  output logic [31:0]          redirect_pc,
  output logic [2:0]           flush,
  output logic [CNT_WIDTH-1:0] br_count,
  output logic [CNT_WIDTH-1:0] mispred_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  br_state_e            state_q;
  logic                 redirect_q;
  logic [31:0]          redirect_pc_q;
  logic [2:0]           flush_q;
  logic [CNT_WIDTH-1:0] br_count_q, br_count_d;
  logic [CNT_WIDTH-1:0] mispred_count_q, mispred_count_d;

  logic [4:0]  opcode;
  logic [2:0]  funct3;
  logic        is_branch, is_jal, is_jalr;
  logic        cond_taken, actual_taken;
  logic [31:0] actual_target, correct_pc;
  logic        resolve, mispredict;
  logic [1:0]  id_ctr;

  assign opcode    = ex_inst[6:2];
  assign funct3    = ex_inst[14:12];
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);

  always_comb begin
    cond_taken = 1'b0;
    case (funct3)
      F3_BEQ:  cond_taken = (ex_rs1 == ex_rs2);
      F3_BNE:  cond_taken = (ex_rs1 != ex_rs2);
      F3_BLT:  cond_taken = ($signed(ex_rs1) < $signed(ex_rs2));
      F3_BGE:  cond_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
      F3_BLTU: cond_taken = (ex_rs1 < ex_rs2);
      F3_BGEU: cond_taken = (ex_rs1 >= ex_rs2);
      default: cond_taken = 1'b0;
    endcase
  end

  // JALR clears bit 0 of the computed address; PC-relative targets are already even.
  always_comb begin
    actual_target = ex_pc + (is_jal ? imm_j(ex_inst) : imm_b(ex_inst));
    if (is_jalr) actual_target = (ex_rs1 + imm_i(ex_inst)) & ~32'd1;
  end

  assign actual_taken = is_jal || is_jalr || (is_branch && cond_taken);
  assign correct_pc   = actual_taken ? actual_target : ex_pc + 32'd4;
  assign resolve      = ex_valid && (state_q == ST_IDLE) && (is_branch || is_jal || is_jalr);
  assign mispredict   = resolve &&
                        ((actual_taken != ex_pred_taken) ||
                         (actual_taken && (ex_pred_target != actual_target)));

  // The FLUSH state swallows the wrong-path instruction that follows a redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
      flush_q       <= 3'b000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mispredict) begin
            state_q       <= ST_FLUSH;
            redirect_q    <= 1'b1;
            redirect_pc_q <= correct_pc;
            flush_q       <= FLUSH_ALL;
          end else begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
            flush_q       <= 3'b000;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          redirect_q    <= 1'b0;
          redirect_pc_q <= 32'd0;
          flush_q       <= 3'b000;
        end
      endcase
    end
  end

  assign br_count_d      = br_count_q + (resolve ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
  assign mispred_count_d = mispred_count_q + (mispredict ? CNT_WIDTH'(1) : CNT_WIDTH'(0));

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  bht_2bit #(
    .BHT_ENTRIES(BHT_ENTRIES)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (id_pc[IDX_W+1:2]),
    .rd_ctr   (id_ctr),
    .upd_en   (resolve && is_branch),
    .upd_idx  (ex_pc[IDX_W+1:2]),
    .upd_taken(actual_taken)
  );

  logic unused_bits;
  assign unused_bits = ^{ex_inst[1:0], id_pc[31:IDX_W+2], id_pc[1:0], id_ctr[0]};

  assign id_pred_taken = id_ctr[1];
  assign redirect      = redirect_q;
  assign redirect_pc   = redirect_pc_q;
  assign flush         = flush_q;
  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule
